if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_pkg.sv | 29 ++
 rtl/if_stage_pc_reg.sv | 41 ++++
 rtl/if_stage.sv | 137 +++++++++++++
 tb/tb_if_stage.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// ============================================================================
// Module      : if_stage_pkg
// Description : Shared widths, constants and fetch FSM state type for the
//               instruction-fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package if_stage_pkg;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 16;
    localparam int REG_W   = 4;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;
    localparam logic [3:0]         OP_HALT   = 4'hF;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_e;

    function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
        return (instr[INSTR_W-1:INSTR_W-4] == OP_HALT);
    endfunction

endpackage : if_stage_pkg

`default_nettype wire

// File: rtl/if_stage_pc_reg.sv
// ============================================================================
// Module      : pc_reg
// Description : Program counter register with load (redirect) taking priority
//               over increment; increment wraps modulo 2^WIDTH.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_reg
    import if_stage_pkg::*;
#(
    parameter int WIDTH = PC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] pc
);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pc_inc;

    assign w_pc_inc = r_pc + {{(WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= '0;
        end else if (load) begin
            r_pc <= load_value;
        end else if (en) begin
            r_pc <= w_pc_inc;
        end
    end

    assign pc = r_pc;

endmodule : pc_reg

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
// Module      : if_stage
// Description : Pipeline fetch stage: PC, IF/ID register and RUN/HALTED FSM.
//               Optional stall counter port enabled by IF_STALL_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_stage
    import if_stage_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               PCWrite,
    input  logic               IFIDWrite,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [PC_W-1:0]    ifid_pc,
    output logic               ifid_valid,
    output logic [REG_W-1:0]   ifid_rs,
    output logic [REG_W-1:0]   ifid_rt,
    output logic               halted
`ifdef IF_STALL_COUNT_EN
    ,
    output logic [15:0]        stall_cycles
`endif
);

    fetch_state_e        r_state;
    fetch_state_e        w_state_next;

    logic [PC_W-1:0]     w_pc;
    logic                w_pc_en;
    logic                w_pc_load;
    logic                w_ifid_nop;
    logic                w_ifid_capture;
    logic                w_halt_seen;

    logic [INSTR_W-1:0]  r_ifid_instr;
    logic [PC_W-1:0]     r_ifid_pc;
    logic                r_ifid_valid;

    pc_reg #(
        .WIDTH      (PC_W)
    ) u_pc_reg (
        .clk        (clk),
        .rst        (rst),
        .en         (w_pc_en),
        .load       (w_pc_load),
        .load_value (branch_target),
        .pc         (w_pc)
    );

    assign w_halt_seen = r_ifid_valid && is_halt(r_ifid_instr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A redirect outranks a HALT sitting in IF/ID, which outranks normal fetch.
    always_comb begin
        w_state_next   = r_state;
        w_pc_en        = 1'b0;
        w_pc_load      = 1'b0;
        w_ifid_nop     = 1'b0;
        w_ifid_capture = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (branch_taken) begin
                    w_pc_load  = 1'b1;
                    w_ifid_nop = 1'b1;
                end else if (w_halt_seen) begin
                    w_state_next = ST_HALTED;
                    w_ifid_nop   = 1'b1;
                end else begin
                    w_pc_en        = PCWrite;
                    w_ifid_capture = IFIDWrite;
                end
            end
            ST_HALTED: begin
                w_ifid_nop = 1'b1;
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    // A bubble keeps the previous ifid_pc; only the instruction and valid change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ifid_instr <= NOP_INSTR;
            r_ifid_pc    <= '0;
            r_ifid_valid <= 1'b0;
        end else if (w_ifid_nop) begin
            r_ifid_instr <= NOP_INSTR;
            r_ifid_valid <= 1'b0;
        end else if (w_ifid_capture) begin
            r_ifid_instr <= imem_data;
            r_ifid_pc    <= w_pc;
            r_ifid_valid <= 1'b1;
        end
    end

`ifdef IF_STALL_COUNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= 16'h0000;
        end else if ((r_state == ST_RUN) && !PCWrite && !branch_taken
                     && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'h0001;
        end
    end

    assign stall_cycles = r_stall_cnt;
`endif

    assign imem_addr  = w_pc;
    assign ifid_instr = r_ifid_instr;
    assign ifid_pc    = r_ifid_pc;
    assign ifid_valid = r_ifid_valid;
    assign ifid_rs    = r_ifid_instr[7:4];
    assign ifid_rt    = r_ifid_instr[3:0];
    assign halted     = (r_state == ST_HALTED);

endmodule : if_stage

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// Module      : tb_if_stage
// Description : Directed self-checking bench for if_stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        PCWrite;
    logic        IFIDWrite;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc;
    logic        ifid_valid;
    logic [3:0]  ifid_rs;
    logic [3:0]  ifid_rt;
    logic        halted;
`ifdef IF_STALL_COUNT_EN
    logic [15:0] stall_cycles;
`endif

    int n_checks;
    int n_fail;

    if_stage dut (
        .clk           (clk),
        .rst           (rst),
        .PCWrite       (PCWrite),
        .IFIDWrite     (IFIDWrite),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .ifid_instr    (ifid_instr),
        .ifid_pc       (ifid_pc),
        .ifid_valid    (ifid_valid),
        .ifid_rs       (ifid_rs),
        .ifid_rt       (ifid_rt),
        .halted        (halted)
`ifdef IF_STALL_COUNT_EN
        ,
        .stall_cycles  (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: addr 0 -> 1234, addr 8 -> HALT, else {1, addr[11:0]}
    always_comb begin
        if (imem_addr == 16'h0000)      imem_data = 16'h1234;
        else if (imem_addr == 16'h0008) imem_data = 16'hF000;
        else                            imem_data = {4'h1, imem_addr[11:0]};
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        PCWrite       = 1'b1;
        IFIDWrite     = 1'b1;
        branch_taken  = 1'b0;
        branch_target = 16'h0000;
        step();
        step();
        check("rst_addr",   imem_addr, 16'h0000);
        check("rst_instr",  ifid_instr, 16'h0000);
        check("rst_ifidpc", ifid_pc, 16'h0000);
        check("rst_valid",  {15'b0, ifid_valid}, 16'h0000);
        check("rst_halted", {15'b0, halted}, 16'h0000);
        rst = 1'b0;

        // first fetch
        step();
        check("f1_instr", ifid_instr, 16'h1234);
        check("f1_pc",    ifid_pc, 16'h0000);
        check("f1_valid", {15'b0, ifid_valid}, 16'h0001);
        check("f1_addr",  imem_addr, 16'h0001);
        check("f1_rs",    {12'b0, ifid_rs}, 16'h0003);
        check("f1_rt",    {12'b0, ifid_rt}, 16'h0004);
        step();
        check("f2_instr", ifid_instr, 16'h1001);
        step();
        step();
        step();
        check("f5_addr",  imem_addr, 16'h0005);
        check("f5_instr", ifid_instr, 16'h1004);

        // two stall cycles at PC=5
        PCWrite   = 1'b0;
        IFIDWrite = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check("stall_addr",  imem_addr, 16'h0005);
            check("stall_instr", ifid_instr, 16'h1004);
            check("stall_pc",    ifid_pc, 16'h0004);
        end
        PCWrite   = 1'b1;
        IFIDWrite = 1'b1;
        step();
        check("resume_addr",  imem_addr, 16'h0006);
        check("resume_instr", ifid_instr, 16'h1005);
        check("resume_pc",    ifid_pc, 16'h0005);

        // redirect with PCWrite low
        branch_taken  = 1'b1;
        branch_target = 16'h0040;
        PCWrite       = 1'b0;
        step();
        check("br_addr",  imem_addr, 16'h0040);
        check("br_valid", {15'b0, ifid_valid}, 16'h0000);
        check("br_instr", ifid_instr, 16'h0000);
        branch_taken = 1'b0;
        PCWrite      = 1'b1;
        step();
        check("br_next_instr", ifid_instr, 16'h1040);
        check("br_next_pc",    ifid_pc, 16'h0040);
        check("br_next_addr",  imem_addr, 16'h0041);

        // PC wrap
        branch_taken  = 1'b1;
        branch_target = 16'hFFFF;
        step();
        check("wrap_pre", imem_addr, 16'hFFFF);
        branch_taken = 1'b0;
        step();
        check("wrap_addr",  imem_addr, 16'h0000);
        check("wrap_ifidpc", ifid_pc, 16'hFFFF);
        check("wrap_instr", ifid_instr, 16'h1FFF);

        // HALT at PC=8
        branch_taken  = 1'b1;
        branch_target = 16'h0008;
        step();
        branch_taken = 1'b0;
        step();
        check("halt_fetch_instr", ifid_instr, 16'hF000);
        check("halt_fetch_addr",  imem_addr, 16'h0009);
        check("halt_fetch_halted", {15'b0, halted}, 16'h0000);
        step();
        check("halt_halted", {15'b0, halted}, 16'h0001);
        check("halt_addr",   imem_addr, 16'h0009);
        check("halt_valid",  {15'b0, ifid_valid}, 16'h0000);
        check("halt_instr",  ifid_instr, 16'h0000);
        branch_taken  = 1'b1;
        branch_target = 16'h0020;
        step();
        check("halt_hold_addr",   imem_addr, 16'h0009);
        check("halt_hold_halted", {15'b0, halted}, 16'h0001);
        branch_taken = 1'b0;

        // asynchronous reset out of HALTED
        #2;
        rst = 1'b1;
        #1;
        check("arst_addr",   imem_addr, 16'h0000);
        check("arst_halted", {15'b0, halted}, 16'h0000);
        step();
        rst = 1'b0;
        step();
        check("arst_f1_instr", ifid_instr, 16'h1234);
        check("arst_f1_addr",  imem_addr, 16'h0001);

        // redirect wins over HALT in IF/ID
        branch_taken  = 1'b1;
        branch_target = 16'h0008;
        step();
        branch_taken = 1'b0;
        step();
        check("bh_instr", ifid_instr, 16'hF000);
        branch_taken  = 1'b1;
        branch_target = 16'h0010;
        step();
        check("bh_halted", {15'b0, halted}, 16'h0000);
        check("bh_addr",   imem_addr, 16'h0010);
        check("bh_valid",  {15'b0, ifid_valid}, 16'h0000);
        branch_taken = 1'b0;
        step();
        check("bh_next_instr", ifid_instr, 16'h1010);
        check("bh_next_pc",    ifid_pc, 16'h0010);

        // reset mid-stall/mid-branch discards the pending update
        PCWrite       = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 16'h0030;
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_addr", imem_addr, 16'h0000);
        step();
        check("mid_rst_hold", imem_addr, 16'h0000);
        rst          = 1'b0;
        PCWrite      = 1'b1;
        branch_taken = 1'b0;
        step();
        check("mid_rst_instr", ifid_instr, 16'h1234);
        check("mid_rst_pc",    ifid_pc, 16'h0000);
        check("mid_rst_valid", {15'b0, ifid_valid}, 16'h0001);

`ifdef IF_STALL_COUNT_EN
        // counter is zero after reset; fetches with PCWrite=1 do not count
        check("stall_cnt_init", stall_cycles, 16'h0000);
        PCWrite   = 1'b0;
        IFIDWrite = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("stall_cnt_3", stall_cycles, 16'h0003);
        branch_taken  = 1'b1;
        branch_target = 16'h0050;
        step();
        check("stall_cnt_br", stall_cycles, 16'h0003);
        branch_taken = 1'b0;
        PCWrite      = 1'b1;
        IFIDWrite    = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_if_stage

`default_nettype wire
